mmio_ctrl: RTL and testbench
============================

MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning data bus width.
REQ-003 SHALL have parameter NLED, default 8, range 1..DATA_W, meaning LED output channel count.
REQ-004 SHALL have parameter NSW, default 8, range 1..DATA_W, meaning switch input channel count.
REQ-005 SHALL have parameters LED_ADDR 9'h100, SW_ADDR 9'h140, SWCHG_ADDR 9'h141 and CNT_ADDR 9'h180, meaning I/O register addresses.
REQ-006 SHALL have parameter DB_CYCLES, default 16, meaning debounce stability length in clk cycles.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have port mem_addr, input, ADDR_W bits: CPU address.
REQ-010 SHALL have port mem_cmd, input, 2 bits: 2'b01 = MREAD, 2'b10 = MWRITE; 00 and 11 are idle.
REQ-011 SHALL have port write_data, input, DATA_W bits: CPU store data.
REQ-012 SHALL have port ram_dout, input, DATA_W bits: RAM read data.
REQ-013 SHALL have port ram_write, output, 1 bit: RAM write enable.
REQ-014 SHALL have port read_data, output, DATA_W bits: CPU load data, always driven with no tristate.
REQ-015 SHALL have port sw, input, NSW bits: asynchronous switch inputs.
REQ-016 SHALL have port led, output, NLED bits: registered LED outputs.

Function
REQ-017 SHALL define msel as mem_addr[ADDR_W-1]==0, and ram_write SHALL equal msel & (mem_cmd==MWRITE), combinationally.
REQ-018 SHALL drive read_data combinationally for mem_cmd==MREAD as follows; in every other case read_data SHALL be 0.
- msel: ram_dout.
- SW_ADDR: zero-extended filtered switches.
- SWCHG_ADDR: zero-extended sticky change flags.
- CNT_ADDR: the counter.
- Any other I/O address: 0.
REQ-019 SHALL load led <= write_data[NLED-1:0] on a clk edge with mem_cmd==MWRITE and mem_addr==LED_ADDR; otherwise led SHALL hold.
REQ-020 SHALL pass each sw bit through a two-flop synchronizer, so a change on sw is visible at SW_ADDR after the 2nd rising edge.
REQ-021 SHALL keep a filtered-switch previous-value register and SHALL set a sticky change flag for bit i on the edge after the filtered bit i differs from its previous value.
REQ-022 SHALL update the change flags at the end of an MREAD of SWCHG_ADDR as flags <= (flags & ~flags_read) | new_changes, so a change coinciding with the clearing read is not lost.
REQ-023 SHALL have a DATA_W-bit counter that increments by 1 every cycle and wraps from all-ones to 0.
REQ-024 SHALL load the counter with write_data on an MWRITE to CNT_ADDR, with the load taking priority over the increment; the counter SHALL increment from the loaded value on the following cycle.
REQ-025 SHALL ignore MWRITE to SW_ADDR, SWCHG_ADDR and unmapped I/O addresses, with no state change.
REQ-026 SHALL neither write state nor clear flags when mem_cmd is idle (00 or 11).

Reset
REQ-027 SHALL, on any clk edge with reset==0, set led, both synchronizer stages, the previous-value register, the change flags, the counter and all debounce state to 0, taking priority over every bus operation.
REQ-028 SHALL, when reset is asserted mid-operation, discard any pending debounce count and set no flag on the first cycle after reset release unless sync stage 2 differs from 0.

Configuration
REQ-029 SHALL provide the macro MMIO_DEBOUNCE_EN.
- Defined: each filtered switch bit SHALL change only after sync stage 2 has differed from it for DB_CYCLES consecutive cycles; a per-channel counter SHALL restart on any bounce.
- Undefined: the filtered value SHALL equal sync stage 2, and no debounce counters SHALL exist.

Structure
REQ-030 SHALL place the MREAD/MWRITE encodings and the default I/O address constants in the shared package mmio_pkg.
REQ-031 SHALL implement per-channel synchronizer, optional debounce and change detection in one sub-module, mmio_sw_chan, instantiated NSW times.

Verification
REQ-032 SHALL cover: reset=0 for 2 cycles, then read LED_ADDR path, SW_ADDR and CNT_ADDR -> led=0, read_data=0, counter=0 on the first cycle after release.
REQ-033 SHALL cover: MWRITE mem_addr=9'h100, write_data=16'hABCD -> led=8'hCD next cycle, ram_write=0; MWRITE 9'h005 -> ram_write=1 in that cycle.
REQ-034 SHALL cover, without the macro: sw 8'h00->8'h5A -> SW_ADDR reads 16'h005A after 2 edges; SWCHG_ADDR reads 16'h005A; a second read returns 0.
REQ-035 SHALL cover: sw bit0 toggles in the same cycle as an SWCHG_ADDR read -> bit0 remains set on the subsequent read.
REQ-036 SHALL cover: MWRITE CNT_ADDR with 16'hFFFE -> reads 16'hFFFF, then 16'h0000 on the following cycles.
REQ-037 SHALL cover, with MMIO_DEBOUNCE_EN and DB_CYCLES=16: sw bit3 pulses high for 10 cycles -> no change; held high for 20 cycles -> SW_ADDR bit3=1 and flag set.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO controller: bus command encodings and default I/O register map.
package mmio_pkg;

    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [8:0] LED_ADDR_DEF   = 9'h100;
    localparam logic [8:0] SW_ADDR_DEF    = 9'h140;
    localparam logic [8:0] SWCHG_ADDR_DEF = 9'h141;
    localparam logic [8:0] CNT_ADDR_DEF   = 9'h180;

    function automatic logic cmd_is(input logic [1:0] cmd, input logic [1:0] code);
        return cmd == code;
    endfunction

endpackage

// File: rtl/mmio_if.sv
// CPU memory bus between the core (master) and the MMIO controller (slave).
// Bus semantics: mem_cmd is sampled every cycle with no handshake; 01 = read, 10 = write, 00/11 = idle.
// read_data and ram_write respond combinationally in the same cycle; writes take effect on the next clk edge.
interface mmio_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_cmd;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_write;
    logic [DATA_W-1:0] read_data;

    modport master (
        output mem_addr, mem_cmd, write_data, ram_dout,
        input  ram_write, read_data
    );

    modport slave (
        input  mem_addr, mem_cmd, write_data, ram_dout,
        output ram_write, read_data
    );
endinterface

// File: rtl/mmio_sw_chan.sv
// One switch channel: two-flop synchronizer, optional debounce (MMIO_DEBOUNCE_EN) and sticky change flag.
module mmio_sw_chan
`ifdef MMIO_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    input  logic clr,
    output logic filt,
    output logic flag
);
    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            flag  <= 1'b0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
            prev  <= filt;
            // A change arriving in the same cycle as a clearing read survives the clear.
            flag  <= (flag & ~clr) | (filt ^ prev);
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [CW-1:0] db_cnt;
    logic          db_filt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            db_cnt  <= '0;
            db_filt <= 1'b0;
        end else if (sync2 != db_filt) begin
            if (db_cnt == CW'(DB_CYCLES - 1)) begin
                db_filt <= sync2;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign filt = db_filt;
`else
    assign filt = sync2;
`endif

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: RAM/I-O address decode, LED register, switch inputs with change flags, free-running counter.
// Optional switch debounce is enabled by defining MMIO_DEBOUNCE_EN.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int                ADDR_W     = 9,
    parameter int                DATA_W     = 16,
    parameter int                NLED       = 8,
    parameter int                NSW        = 8,
    parameter logic [ADDR_W-1:0] LED_ADDR   = LED_ADDR_DEF,
    parameter logic [ADDR_W-1:0] SW_ADDR    = SW_ADDR_DEF,
    parameter logic [ADDR_W-1:0] SWCHG_ADDR = SWCHG_ADDR_DEF,
    parameter logic [ADDR_W-1:0] CNT_ADDR   = CNT_ADDR_DEF,
    parameter int                DB_CYCLES  = 16
) (
    input  logic            clk,
    input  logic            reset,
    mmio_if.slave           bus,
    input  logic [NSW-1:0]  sw,
    output logic [NLED-1:0] led
);
    logic              msel;
    logic              is_rd;
    logic              is_wr;
    logic              swchg_rd;
    logic [NSW-1:0]    sw_filt;
    logic [NSW-1:0]    sw_flag;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] rd;

    // Out-of-range channel counts or a zero debounce length yield no usable hardware.
    if (NLED < 1 || NLED > DATA_W || NSW < 1 || NSW > DATA_W || DB_CYCLES < 1) begin : g_param_range_invalid
    end

    assign msel     = ~bus.mem_addr[ADDR_W-1];
    assign is_rd    = cmd_is(bus.mem_cmd, MREAD);
    assign is_wr    = cmd_is(bus.mem_cmd, MWRITE);
    assign swchg_rd = is_rd & ~msel & (bus.mem_addr == SWCHG_ADDR);

    assign bus.ram_write = msel & is_wr;

    for (genvar i = 0; i < NSW; i++) begin : g_sw
`ifdef MMIO_DEBOUNCE_EN
        mmio_sw_chan #(.DB_CYCLES(DB_CYCLES)) u_chan (
`else
        mmio_sw_chan u_chan (
`endif
            .clk   (clk),
            .reset (reset),
            .sw_in (sw[i]),
            .clr   (swchg_rd),
            .filt  (sw_filt[i]),
            .flag  (sw_flag[i])
        );
    end

    always_comb begin
        rd = '0;
        if (is_rd) begin
            if (msel) begin
                rd = bus.ram_dout;
            end else if (bus.mem_addr == SW_ADDR) begin
                rd[NSW-1:0] = sw_filt;
            end else if (bus.mem_addr == SWCHG_ADDR) begin
                rd[NSW-1:0] = sw_flag;
            end else if (bus.mem_addr == CNT_ADDR) begin
                rd = cnt;
            end
        end
    end

    assign bus.read_data = rd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            led <= '0;
        end else if (is_wr && bus.mem_addr == LED_ADDR) begin
            led <= bus.write_data[NLED-1:0];
        end
    end

    // A CPU load of the counter wins over the free-running increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (is_wr && bus.mem_addr == CNT_ADDR) begin
            cnt <= bus.write_data;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed self-checking bench for mmio_ctrl; debounce vectors run only when MMIO_DEBOUNCE_EN is defined.
module tb_mmio_ctrl;
    import mmio_pkg::*;

    localparam int DB = 16;
`ifdef MMIO_DEBOUNCE_EN
    localparam int SW_LAT = 2 + DB;
`else
    localparam int SW_LAT = 2;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sw    = 8'h00;
    logic [7:0] led;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    mmio_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    mmio_ctrl #(
        .ADDR_W    (9),
        .DATA_W    (16),
        .NLED      (8),
        .NSW       (8),
        .DB_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .sw    (sw),
        .led   (led)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic bus_set(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wd;
        #1;
    endtask

    task automatic bus_cycle(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
        @(negedge clk);
        bus_set(cmd, addr, wd);
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(2'b00, 9'h000, 16'h0000);
    endtask

    initial begin
        bus.mem_cmd    = 2'b00;
        bus.mem_addr   = '0;
        bus.write_data = '0;
        bus.ram_dout   = 16'hBEEF;

        // reset held for two edges, checked on the first cycle after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus_set(MREAD, 9'h100, 16'h0000);
        check("rst_rd_led_addr", bus.read_data, 16'h0000);
        check("rst_led", led, 8'h00);
        bus_set(MREAD, 9'h140, 16'h0000);
        check("rst_rd_sw", bus.read_data, 16'h0000);
        bus_set(MREAD, 9'h180, 16'h0000);
        check("rst_cnt", bus.read_data, 16'h0000);
        bus_cycle(MREAD, 9'h180, 16'h0000);
        check("cnt_first_inc", bus.read_data, 16'h0001);

        // LED register and RAM write enable
        bus_cycle(MWRITE, 9'h100, 16'hABCD);
        check("led_wr_ram_write", bus.ram_write, 1'b0);
        check("wr_read_data_zero", bus.read_data, 16'h0000);
        bus_cycle(MWRITE, 9'h005, 16'h1111);
        check("ram_wr_ram_write", bus.ram_write, 1'b1);
        check("led_loaded", led, 8'hCD);
        bus_cycle(MREAD, 9'h005, 16'h0000);
        check("ram_rd_data", bus.read_data, 16'hBEEF);
        check("ram_rd_no_write", bus.ram_write, 1'b0);

        // ignored writes and idle commands
        bus_cycle(MWRITE, 9'h140, 16'hFFFF);
        bus_cycle(MWRITE, 9'h1FF, 16'hFFFF);
        bus_cycle(2'b11, 9'h100, 16'h1234);
        check("idle11_ram_write", bus.ram_write, 1'b0);
        bus_cycle(MREAD, 9'h1FF, 16'h0000);
        check("rd_unmapped", bus.read_data, 16'h0000);
        check("led_held", led, 8'hCD);
        bus_cycle(2'b11, 9'h180, 16'h0000);
        check("idle11_read_data", bus.read_data, 16'h0000);

        // counter load and wrap
        bus_cycle(MWRITE, 9'h180, 16'hFFFE);
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        while (exp_q.size() > 0) begin
            bus_cycle(MREAD, 9'h180, 16'h0000);
            check("cnt_load_wrap", bus.read_data, exp_q.pop_front());
        end

        // switch path and change flags
        @(negedge clk);
        sw = 8'h5A;
        bus_set(MREAD, 9'h140, 16'h0000);
        check("sw_not_yet", bus.read_data, 16'h0000);
        repeat (SW_LAT - 1) bus_cycle(MREAD, 9'h140, 16'h0000);
        check("sw_before_lat", bus.read_data, 16'h0000);
        bus_cycle(MREAD, 9'h140, 16'h0000);
        check("sw_visible", bus.read_data, 16'h005A);
        bus_cycle(MREAD, 9'h141, 16'h0000);
        check("swchg_set", bus.read_data, 16'h005A);
        bus_cycle(MREAD, 9'h141, 16'h0000);
        check("swchg_cleared", bus.read_data, 16'h0000);

        // bit0 change coinciding with a clearing read is kept
        @(negedge clk);
        sw = 8'h58;
        bus_set(2'b00, 9'h000, 16'h0000);
        idle(SW_LAT + 1);
        sw = 8'h59;
        idle(SW_LAT - 1);
        bus_cycle(MREAD, 9'h141, 16'h0000);
        check("swchg_bit1_only", bus.read_data, 16'h0002);
        bus_cycle(MREAD, 9'h141, 16'h0000);
        check("swchg_coincide_kept", bus.read_data, 16'h0001);
        bus_cycle(MREAD, 9'h140, 16'h0000);
        check("sw_after_toggle", bus.read_data, 16'h0059);

`ifdef MMIO_DEBOUNCE_EN
        sw = 8'h51;
        idle(SW_LAT + 1);
        bus_cycle(MREAD, 9'h141, 16'h0000);
        check("db_fall_flag", bus.read_data, 16'h0008);
        sw = 8'h59;
        idle(10);
        sw = 8'h51;
        idle(30);
        bus_cycle(MREAD, 9'h140, 16'h0000);
        check("db_short_pulse_sw", bus.read_data, 16'h0051);
        bus_cycle(MREAD, 9'h141, 16'h0000);
        check("db_short_pulse_flag", bus.read_data, 16'h0000);
        sw = 8'h59;
        idle(20);
        bus_cycle(MREAD, 9'h140, 16'h0000);
        check("db_long_hold_sw", bus.read_data, 16'h0059);
        bus_cycle(MREAD, 9'h141, 16'h0000);
        check("db_long_hold_flag", bus.read_data, 16'h0008);
`endif

        // reset during activity wins over bus writes and drops switch state
        @(negedge clk);
        reset = 1'b0;
        sw    = 8'hFF;
        bus_set(MWRITE, 9'h100, 16'hFFFF);
        bus_cycle(MWRITE, 9'h180, 16'h1234);
        @(negedge clk);
        reset = 1'b1;
        bus_set(MREAD, 9'h141, 16'h0000);
        check("rst2_swchg", bus.read_data, 16'h0000);
        check("rst2_led", led, 8'h00);
        bus_set(MREAD, 9'h140, 16'h0000);
        check("rst2_sw", bus.read_data, 16'h0000);
        bus_set(MREAD, 9'h180, 16'h0000);
        check("rst2_cnt", bus.read_data, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
